// File: rtl/magnitude_pkg.sv
// -----------------------------------------------------------------------------
// magnitude_pkg
// Shared types and constants for the sqrt scheduler slice.
//   sched_state_e : scheduler FSM state encoding
//   sat_limit()   : largest value representable in an unsigned field of width w
//   SAT_LIMIT     : saturation limit for the default 8-bit colour channel
// -----------------------------------------------------------------------------
package magnitude_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUTPUT = 2'd3
    } sched_state_e;

    localparam int unsigned COLOR_CHANNEL_DEF = 8;

    function automatic int unsigned sat_limit(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    localparam int unsigned SAT_LIMIT = sat_limit(COLOR_CHANNEL_DEF);

endpackage : magnitude_pkg

// File: rtl/sqrt_scheduler_if.sv
// -----------------------------------------------------------------------------
// sqrt_scheduler_if
// Requester handshake and sqrt-core handshake of the scheduler.
//   i_req_valid   : per-requester operand valid
//   i_req_data    : per-requester operand
//   o_req_ready   : one-hot accept strobe
//   o_sqrt_start  : one-cycle start pulse to the shared sqrt core
//   o_sqrt_data   : operand presented to the core
//   i_sqrt_done   : core result-valid pulse
//   i_sqrt_result : core root
// Modports: master = scheduler side, slave = requesters/core side.
// -----------------------------------------------------------------------------
interface sqrt_scheduler_if #(
    parameter int DATA_SIZE = 18,
    parameter int NUM_REQ   = 3
);
    localparam int RW = (DATA_SIZE + 1) / 2;

    logic [NUM_REQ-1:0]                i_req_valid;
    logic [NUM_REQ-1:0][DATA_SIZE-1:0] i_req_data;
    logic [NUM_REQ-1:0]                o_req_ready;
    logic                              o_sqrt_start;
    logic [DATA_SIZE-1:0]              o_sqrt_data;
    logic                              i_sqrt_done;
    logic [RW-1:0]                     i_sqrt_result;

    modport master (
        input  i_req_valid,
        input  i_req_data,
        output o_req_ready,
        output o_sqrt_start,
        output o_sqrt_data,
        input  i_sqrt_done,
        input  i_sqrt_result
    );

    modport slave (
        output i_req_valid,
        output i_req_data,
        input  o_req_ready,
        input  o_sqrt_start,
        input  o_sqrt_data,
        output i_sqrt_done,
        output i_sqrt_result
    );

endinterface : sqrt_scheduler_if

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: searches the request vector starting at
// (last_grant_i + 1) mod NUM_REQ and returns the first requester found.
//   req_i         : request vector
//   last_grant_i  : index of the previously granted requester
//   grant_o       : one-hot grant (all zero when nobody requests)
//   grant_idx_o   : index of the granted requester
//   grant_valid_o : a grant was found
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDW-1:0]     grant_idx_o,
    output logic               grant_valid_o
);

    always_comb begin
        logic [IDW-1:0] cidx;
        int unsigned    cand;
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        cidx          = '0;
        cand          = 0;
        // Offsets 1..NUM_REQ so the last granted requester is checked last.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last_grant_i) + k) % NUM_REQ;
            cidx = IDW'(cand);
            if (!grant_valid_o && req_i[cidx]) begin
                grant_valid_o = 1'b1;
                grant_o[cidx] = 1'b1;
                grant_idx_o   = cidx;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/sqrt_scheduler.sv
// -----------------------------------------------------------------------------
// sqrt_scheduler
// Shares one iterative sqrt core between NUM_REQ requesters. One operation is
// in flight at a time: grant (IDLE) -> start pulse (ISSUE) -> wait for done
// or timeout (WAIT) -> one-cycle result strobe (OUTPUT).
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   bus              : requester + core handshake (master modport)
//   o_data_ready     : one-cycle result strobe
//   o_data           : root saturated to COLOR_CHANNEL bits
//   o_data_id        : requester index that o_data belongs to
//   o_err            : sticky error (timeout or done outside WAIT)
// -----------------------------------------------------------------------------
module sqrt_scheduler
    import magnitude_pkg::*;
#(
    parameter int DATA_SIZE     = 18,
    parameter int NUM_REQ       = 3,
    parameter int COLOR_CHANNEL = 8,
    parameter int TIMEOUT       = 64
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    sqrt_scheduler_if.master           bus,
    output logic                       o_data_ready,
    output logic [COLOR_CHANNEL-1:0]   o_data,
    output logic [$clog2(NUM_REQ)-1:0] o_data_id,
    output logic                       o_err
);

    localparam int          IDW   = $clog2(NUM_REQ);
    localparam int          CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned LIMIT = sat_limit(COLOR_CHANNEL);

    sched_state_e             state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDW-1:0]           last_q, last_d;
    logic [IDW-1:0]           gid_q, gid_d;
    logic [DATA_SIZE-1:0]     op_q, op_d;
    logic [COLOR_CHANNEL-1:0] data_q, data_d;
    logic [IDW-1:0]           id_q, id_d;
    logic                     err_q, err_d;

    logic [NUM_REQ-1:0]       grant;
    logic [IDW-1:0]           grant_idx;
    logic                     grant_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req_i         (bus.i_req_valid),
        .last_grant_i  (last_q),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= IDW'(NUM_REQ - 1);
            gid_q   <= '0;
            op_q    <= '0;
            data_q  <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            op_q    <= op_d;
            data_q  <= data_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gid_d   = gid_q;
        op_d    = op_q;
        data_d  = data_q;
        id_d    = id_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_sqrt_done) err_d = 1'b1;
                if (grant_valid) begin
                    op_d    = bus.i_req_data[grant_idx];
                    gid_d   = grant_idx;
                    last_d  = grant_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.i_sqrt_done) err_d = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // done is tested first so it wins over a same-cycle timeout.
                if (bus.i_sqrt_done) begin
                    data_d  = (32'(bus.i_sqrt_result) > LIMIT) ? COLOR_CHANNEL'(LIMIT)
                                                               : COLOR_CHANNEL'(bus.i_sqrt_result);
                    id_d    = gid_q;
                    state_d = ST_OUTPUT;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (bus.i_sqrt_done) err_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant is combinational from the live request vector; masked by reset so
    // nothing is offered while the block is held in reset.
    assign bus.o_req_ready  = (state_q == ST_IDLE && i_reset_n) ? grant : '0;
    assign bus.o_sqrt_start = (state_q == ST_ISSUE);
    assign bus.o_sqrt_data  = op_q;
    assign o_data_ready     = (state_q == ST_OUTPUT);
    assign o_data           = data_q;
    assign o_data_id        = id_q;
    assign o_err            = err_q;

endmodule : sqrt_scheduler

// File: tb/tb_sqrt_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sqrt_scheduler
// Directed scenarios followed by randomized traffic. A cycle-level reference
// model derived from the operation timeline (grant, start, wait window,
// result) checks every DUT output on every falling edge; directed scenarios
// add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_sqrt_scheduler;

    localparam int DS  = 18;
    localparam int NR  = 3;
    localparam int CC  = 8;
    localparam int TO  = 64;
    localparam int RW  = (DS + 1) / 2;
    localparam int IDW = 2;
    localparam int LIM = (1 << CC) - 1;

    logic           i_clk = 1'b0;
    logic           i_reset_n = 1'b1;
    logic           o_data_ready;
    logic [CC-1:0]  o_data;
    logic [IDW-1:0] o_data_id;
    logic           o_err;

    sqrt_scheduler_if #(.DATA_SIZE(DS), .NUM_REQ(NR)) bus ();

    sqrt_scheduler #(
        .DATA_SIZE     (DS),
        .NUM_REQ       (NR),
        .COLOR_CHANNEL (CC),
        .TIMEOUT       (TO)
    ) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .bus          (bus),
        .o_data_ready (o_data_ready),
        .o_data       (o_data),
        .o_data_id    (o_data_id),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] isqrt(input logic [DS-1:0] x);
        int unsigned r = 0;
        while ((r + 1) * (r + 1) <= 32'(x)) r++;
        return RW'(r);
    endfunction

    // ---------------- sqrt core emulation ----------------
    int            core_lat = 3;     // 0 = never answers
    bit            inj_done = 1'b0;  // one spurious done pulse
    logic [RW-1:0] inj_res  = '0;

    initial begin
        int            cnt;
        logic [DS-1:0] held;
        logic          s_start;
        logic [DS-1:0] s_op;
        cnt = 0;
        held = '0;
        bus.i_sqrt_done   = 1'b0;
        bus.i_sqrt_result = '0;
        forever begin
            @(negedge i_clk);
            s_start = bus.o_sqrt_start;
            s_op    = bus.o_sqrt_data;
            @(posedge i_clk);
            #1;
            if (s_start && core_lat > 0) begin
                cnt  = core_lat;
                held = s_op;
            end
            bus.i_sqrt_done = 1'b0;
            if (cnt > 0) begin
                if (cnt == 1) begin
                    bus.i_sqrt_done   = 1'b1;
                    bus.i_sqrt_result = isqrt(held);
                end
                cnt--;
            end
            if (inj_done) begin
                bus.i_sqrt_done   = 1'b1;
                bus.i_sqrt_result = inj_res;
                inj_done = 1'b0;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    initial begin
        bit            m_busy, m_outp, m_err, dn;
        int            m_age, m_last, m_gid, m_id, pick, c;
        logic [DS-1:0] m_op;
        logic [CC-1:0] m_data;
        logic [NR-1:0] v, exp_rdy;
        m_busy = 0; m_outp = 0; m_err = 0; m_age = 0; m_last = NR - 1;
        m_gid = 0; m_id = 0; m_op = '0; m_data = '0;
        forever begin
            @(negedge i_clk);
            if (!i_reset_n) begin
                m_busy = 0; m_outp = 0; m_err = 0; m_age = 0; m_last = NR - 1;
                m_gid = 0; m_id = 0; m_op = '0; m_data = '0;
                chk("rst_ready", bus.o_req_ready, 0);
                chk("rst_start", bus.o_sqrt_start, 0);
                chk("rst_sdata", bus.o_sqrt_data, 0);
                chk("rst_dready", o_data_ready, 0);
                chk("rst_data", o_data, 0);
                chk("rst_id", o_data_id, 0);
                chk("rst_err", o_err, 0);
            end else begin
                v = bus.i_req_valid;
                dn = bus.i_sqrt_done;
                pick = -1;
                if (!m_busy && !m_outp)
                    for (int k = 1; k <= NR; k++) begin
                        c = (m_last + k) % NR;
                        if (pick < 0 && v[c]) pick = c;
                    end
                exp_rdy = (pick >= 0) ? (3'(1) << pick) : '0;
                chk("m_ready", bus.o_req_ready, exp_rdy);
                chk("m_start", bus.o_sqrt_start, (m_busy && m_age == 0));
                chk("m_sdata", bus.o_sqrt_data, m_op);
                chk("m_dready", o_data_ready, m_outp);
                chk("m_data", o_data, m_data);
                chk("m_id", o_data_id, m_id);
                chk("m_err", o_err, m_err);
                // advance the operation timeline by one clock
                if (m_outp) begin
                    m_outp = 0;
                    if (dn) m_err = 1;
                end else if (!m_busy) begin
                    if (dn) m_err = 1;
                    if (pick >= 0) begin
                        m_busy = 1; m_age = 0; m_op = bus.i_req_data[pick];
                        m_gid = pick; m_last = pick;
                    end
                end else if (m_age == 0) begin
                    if (dn) m_err = 1;
                    m_age = 1;
                end else begin
                    // m_age-1 is the number of WAIT cycles already spent
                    if (dn) begin
                        m_busy = 0; m_outp = 1; m_id = m_gid;
                        m_data = (int'(bus.i_sqrt_result) > LIM) ? CC'(LIM) : CC'(bus.i_sqrt_result);
                    end else if (m_age == TO) begin
                        m_busy = 0; m_err = 1;
                    end else begin
                        m_age++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        bus.i_req_valid = '0;
        ticks(2);
        i_reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_grant(input int maxc, output bit ok, output int t);
        ok = 0; t = 0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge i_clk);
            if (bus.o_req_ready != '0) begin ok = 1; t = cyc; end
        end
    endtask

    task automatic wait_dr(input int maxc, output bit ok, output int t);
        ok = 0; t = 0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge i_clk);
            if (o_data_ready) begin ok = 1; t = cyc; end
        end
    endtask

    initial begin
        bit            ok;
        int            t0, t1, nd;
        logic [DS-1:0] opnd;
        bus.i_req_valid = '0;
        bus.i_req_data  = '0;
        #1 i_reset_n = 1'b0;
        ticks(3);
        i_reset_n = 1'b1;
        tick();

        // single request, L = 9
        core_lat = 9;
        bus.i_req_data[0] = 18'd400;
        bus.i_req_valid = 3'b001;
        wait_grant(5, ok, t0);
        chk("single_grant", bus.o_req_ready, 3'b001);
        tick();
        bus.i_req_valid = '0;
        wait_dr(30, ok, t1);
        chk("single_found", ok, 1);
        chk("single_latency", t1 - t0, 11);
        chk("single_data", o_data, 20);
        chk("single_id", o_data_id, 0);
        chk("single_err", o_err, 0);
        tick();

        // saturation
        core_lat = 4;
        bus.i_req_data[0] = 18'd160000;
        bus.i_req_valid = 3'b001;
        wait_grant(5, ok, t0);
        tick();
        bus.i_req_valid = '0;
        wait_dr(20, ok, t1);
        chk("sat_found", ok, 1);
        chk("sat_data", o_data, 255);
        chk("sat_id", o_data_id, 0);
        tick();

        // fairness: everyone requesting, L = 3
        do_reset();
        core_lat = 3;
        for (int k = 0; k < NR; k++) bus.i_req_data[k] = DS'($urandom);
        bus.i_req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            wait_grant(20, ok, t0);
            chk("fair_found", ok, 1);
            chk("fair_grant", bus.o_req_ready, 3'(1) << (k % 3));
            tick();
            @(negedge i_clk);
            chk("fair_pulse", bus.o_req_ready, 0);
        end
        tick();
        bus.i_req_valid = '0;
        ticks(8);

        // done lands in the final WAIT cycle: result wins, no error
        core_lat = TO;
        opnd = DS'($urandom);
        bus.i_req_data[1] = opnd;
        bus.i_req_valid = 3'b010;
        wait_grant(5, ok, t0);
        tick();
        bus.i_req_valid = '0;
        wait_dr(80, ok, t1);
        chk("edge_found", ok, 1);
        chk("edge_latency", t1 - t0, 2 + TO);
        chk("edge_err", o_err, 0);
        chk("edge_id", o_data_id, 1);
        chk("edge_data", o_data, (int'(isqrt(opnd)) > LIM) ? LIM : int'(isqrt(opnd)));
        tick();

        // timeout: core never answers
        core_lat = 0;
        bus.i_req_data[0] = DS'($urandom);
        bus.i_req_valid = 3'b001;
        wait_grant(5, ok, t0);
        tick();
        bus.i_req_valid = '0;
        nd = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge i_clk);
            if (o_data_ready) nd++;
        end
        chk("to_no_result", nd, 0);
        chk("to_err", o_err, 1);
        tick();
        core_lat = 5;
        opnd = 18'd10000;
        bus.i_req_data[2] = opnd;
        bus.i_req_valid = 3'b100;
        wait_grant(5, ok, t0);
        chk("to_next_grant", bus.o_req_ready, 3'b100);
        tick();
        bus.i_req_valid = '0;
        wait_dr(20, ok, t1);
        chk("to_next_found", ok, 1);
        chk("to_next_data", o_data, 100);
        chk("to_next_id", o_data_id, 2);
        tick();

        // spurious done while idle
        do_reset();
        inj_res = 9'd77;
        inj_done = 1'b1;
        ticks(3);
        @(negedge i_clk);
        chk("spur_err", o_err, 1);
        chk("spur_data", o_data, 0);
        chk("spur_dready", o_data_ready, 0);
        tick();

        // reset while waiting, then a late done
        do_reset();
        core_lat = 20;
        bus.i_req_data[1] = 18'd1234;
        bus.i_req_valid = 3'b010;
        wait_grant(5, ok, t0);
        tick();
        bus.i_req_valid = '0;
        ticks(6);
        i_reset_n = 1'b0;
        bus.i_req_valid = 3'b111;
        @(negedge i_clk);
        chk("rw_ready", bus.o_req_ready, 0);
        chk("rw_start", bus.o_sqrt_start, 0);
        chk("rw_sdata", bus.o_sqrt_data, 0);
        chk("rw_dready", o_data_ready, 0);
        chk("rw_data", o_data, 0);
        chk("rw_id", o_data_id, 0);
        chk("rw_err", o_err, 0);
        tick();
        bus.i_req_valid = '0;
        i_reset_n = 1'b1;
        core_lat = 3;
        ticks(20);
        @(negedge i_clk);
        chk("late_done_err", o_err, 1);
        tick();
        bus.i_req_valid = 3'b111;
        @(negedge i_clk);
        chk("post_rst_grant", bus.o_req_ready, 3'b001);
        tick();
        bus.i_req_valid = '0;
        ticks(10);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.i_req_valid = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
            for (int k = 0; k < NR; k++) bus.i_req_data[k] = DS'($urandom);
            if ($urandom_range(0, 15) == 0)
                core_lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            if ($urandom_range(0, 299) == 0) begin
                inj_res = RW'($urandom);
                inj_done = 1'b1;
            end
            i_reset_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        i_reset_n = 1'b1;
        bus.i_req_valid = '0;
        ticks(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sqrt_scheduler

// File: doc/sqrt_scheduler.md
SQRT_SCHEDULER -- requirements
Module: sqrt_scheduler

Interface
REQ-001 Parameter DATA_SIZE, default 18: width of each squared-magnitude operand.
REQ-002 Parameter NUM_REQ, default 3: number of requesters (one per colour channel), range 2..8.
REQ-003 Parameter COLOR_CHANNEL, default 8: output pixel width.
REQ-004 Parameter TIMEOUT, default 64: maximum WAIT cycles before abort.
REQ-005 Ports:
  - i_clk, input, 1: sole clock, rising edge.
  - i_reset_n, input, 1: asynchronous active-low reset.
  - i_req_valid, input, NUM_REQ: per-requester operand valid.
  - i_req_data, input, NUM_REQ x DATA_SIZE: per-requester operand.
  - o_req_ready, output, NUM_REQ: one-hot accept strobe.
  - o_sqrt_start, output, 1: one-cycle start pulse to the shared iterative sqrt core.
  - o_sqrt_data, output, DATA_SIZE: operand to the core.
  - i_sqrt_done, input, 1: core result-valid pulse.
  - i_sqrt_result, input, (DATA_SIZE+1)/2: core root.
  - o_data_ready, output, 1: one-cycle result strobe.
  - o_data, output, COLOR_CHANNEL: saturated root.
  - o_data_id, output, clog2(NUM_REQ): requester index of o_data.
  - o_err, output, 1: sticky protocol/timeout error.

Function
REQ-006 The FSM SHALL have the states IDLE, ISSUE, WAIT and OUTPUT.
REQ-007 In IDLE with any i_req_valid set, the block SHALL grant round-robin, starting at (last_grant+1) mod NUM_REQ.
REQ-008 In IDLE, o_req_ready[g] SHALL be driven combinationally in the same cycle as the grant, with at most one bit high; o_req_ready SHALL be all-zero in every other state.
REQ-009 On the grant edge, the block SHALL capture i_req_data[g] and g, update last_grant, and go to ISSUE.
REQ-010 ISSUE SHALL last exactly one cycle, with o_sqrt_start=1 and o_sqrt_data=captured operand, then go to WAIT; o_sqrt_data SHALL hold the operand through WAIT.
REQ-011 WAIT: on i_sqrt_done=1, the block SHALL register i_sqrt_result and go to OUTPUT.
REQ-012 WAIT: a cycle counter SHALL start at 0 on WAIT entry; when it reaches TIMEOUT-1 without done, the block SHALL set o_err, go to IDLE, and emit no result.
REQ-013 If done and the timeout condition occur in the same cycle, done SHALL take priority.
REQ-014 OUTPUT SHALL last one cycle, with o_data_ready=1, o_data_id=g and o_data=min(result, 2^COLOR_CHANNEL-1), then go to IDLE.
REQ-015 o_data and o_data_id SHALL hold their values until the next OUTPUT.
REQ-016 Latency: accept at cycle T, start at T+1; with done at T+1+L (L>=1), o_data_ready SHALL be high at T+2+L.
REQ-017 Throughput: the block SHALL have at most one operation in flight; a new grant SHALL be possible no earlier than the cycle after OUTPUT.
REQ-018 i_sqrt_done sampled high in IDLE, ISSUE or OUTPUT SHALL be ignored for data and SHALL set o_err.
REQ-019 o_err SHALL clear only on reset.
REQ-020 A requester dropping i_req_valid while not granted SHALL lose no state; no queueing SHALL be done.

Reset
REQ-021 Asserting i_reset_n low SHALL immediately force state=IDLE and set these outputs to 0: o_req_ready, o_sqrt_start, o_sqrt_data, o_data_ready, o_data, o_data_id and o_err.
REQ-022 Reset SHALL also clear the timeout counter and set last_grant=NUM_REQ-1, so the first grant goes to requester 0.
REQ-023 Reset mid-operation SHALL abandon the operation; a late i_sqrt_done after reset release, while in IDLE, SHALL set o_err per REQ-018.

Structure
REQ-024 The state enum typedef and the saturation-limit constant SHALL live in the shared package magnitude_pkg.
REQ-025 Round-robin grant logic SHALL be a separate sub-module, rr_arbiter (request vector and last_grant in, one-hot grant and index out).
REQ-026 The FSM, counter and saturation SHALL reside in sqrt_scheduler.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
  - Single request: req0 valid, data=400, done after L=9 with result=20 -> o_data_ready at T+11, o_data=20, o_data_id=0, o_err=0.
  - Saturation: data=160000, result=400 -> o_data=255.
  - Fairness: all three valid continuously, core L=3 -> grant order 0,1,2,0,1,2 and each o_req_ready a single-cycle one-hot pulse.
  - Timeout: no done for 64 WAIT cycles -> o_err=1, no o_data_ready, next grant proceeds normally.
  - Spurious done: i_sqrt_done in IDLE -> o_err=1 and o_data unchanged; done coincident with timeout cycle -> result delivered and o_err stays 0.
  - Reset in WAIT, then a late done -> all outputs 0 during reset, o_err=1 after the late done, and the first post-reset grant goes to requester 0.
